// File: rtl/x_gate_sv_engine_pkg.sv
// Shared definitions for the sequential single-qubit gate engines: fixed-point width,
// FSM encoding and the basis-pair iteration helper.
package x_gate_sv_engine_pkg;

    localparam int TOTAL_WIDTH = 16;
    localparam int IDX_MAX_W   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SWAP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Insert a zero at bit position t of pair counter k, giving the lower index of pair k.
    function automatic logic [IDX_MAX_W-1:0] insert_zero_bit(
        input logic [IDX_MAX_W-1:0] k,
        input logic [2:0]           t
    );
        logic [IDX_MAX_W-1:0] low_mask;
        low_mask = (8'd1 << t) - 8'd1;
        return ((k & ~low_mask) << 1) | (k & low_mask);
    endfunction

endpackage

// File: rtl/x_gate_sv_engine_pair_index_gen.sv
// Combinational pair-index generator: maps pair counter k and target t to the basis
// indices i0 (bit t clear) and i1 (bit t set).
module x_pair_index_gen
    import x_gate_sv_engine_pkg::*;
#(
    parameter int AW = 3,
    parameter int TW = 2
)(
    input  logic [AW-1:0] k,
    input  logic [TW-1:0] t,
    output logic [AW-1:0] i0,
    output logic [AW-1:0] i1
);

    logic [IDX_MAX_W-1:0] i0_wide_s;

    // Expand the counter into the pair's two basis indices.
    always_comb begin
        i0_wide_s = insert_zero_bit(IDX_MAX_W'(k), 3'(t));
        i0        = AW'(i0_wide_s);
        i1        = i0 | (AW'(1) << t);
    end

endmodule

// File: rtl/x_gate_sv_engine.sv
// Sequential X-gate engine over a 2^N amplitude register file, one swapped pair per cycle.
// Optional controlled-X support is enabled by defining CONTROLLED_X_EN.
module x_gate_sv_engine
    import x_gate_sv_engine_pkg::*;
#(
    parameter  int NUM_QUBITS = 3,
    localparam int DEPTH      = 1 << NUM_QUBITS,
    localparam int AW         = $clog2(DEPTH),
    localparam int TW         = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_we,
    input  logic [AW-1:0]                 ld_addr,
    input  logic signed [TOTAL_WIDTH-1:0] ld_re,
    input  logic signed [TOTAL_WIDTH-1:0] ld_im,
    input  logic [AW-1:0]                 rd_addr,
    output logic signed [TOTAL_WIDTH-1:0] rd_re,
    output logic signed [TOTAL_WIDTH-1:0] rd_im,
    input  logic                          start,
    input  logic [TW-1:0]                 target,
`ifdef CONTROLLED_X_EN
    input  logic                          ctrl_en,
    input  logic [TW-1:0]                 ctrl,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [AW-1:0] K_LAST = AW'(DEPTH / 2 - 1);
    localparam logic [TW:0]   NQ_W   = (TW + 1)'(NUM_QUBITS);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [TW-1:0] t_q, t_d;
    logic          cmd_err_q, cmd_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bad_cmd_s;
    logic          swap_en_s;
    logic [AW-1:0] i0_s, i1_s;

    logic signed [TOTAL_WIDTH-1:0] amp_re_q [DEPTH];
    logic signed [TOTAL_WIDTH-1:0] amp_im_q [DEPTH];
    logic signed [TOTAL_WIDTH-1:0] amp_re_d [DEPTH];
    logic signed [TOTAL_WIDTH-1:0] amp_im_d [DEPTH];
    logic signed [TOTAL_WIDTH-1:0] rd_re_q, rd_re_d;
    logic signed [TOTAL_WIDTH-1:0] rd_im_q, rd_im_d;

`ifdef CONTROLLED_X_EN
    logic          ctrl_en_q, ctrl_en_d;
    logic [TW-1:0] ctrl_q, ctrl_d;
`endif

    x_pair_index_gen #(
        .AW (AW),
        .TW (TW)
    ) u_pair_index_gen (
        .k  (k_q),
        .t  (t_q),
        .i0 (i0_s),
        .i1 (i1_s)
    );

    // Command FSM, pair counter and status outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        cmd_err_d = cmd_err_q;
`ifdef CONTROLLED_X_EN
        ctrl_en_d = ctrl_en_q;
        ctrl_d    = ctrl_q;
        bad_cmd_s = ({1'b0, target} >= NQ_W) ||
                    (ctrl_en && (({1'b0, ctrl} >= NQ_W) || (ctrl == target)));
`else
        bad_cmd_s = ({1'b0, target} >= NQ_W);
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    t_d       = target;
                    k_d       = {AW{1'b0}};
                    cmd_err_d = bad_cmd_s;
`ifdef CONTROLLED_X_EN
                    ctrl_en_d = ctrl_en;
                    ctrl_d    = ctrl;
`endif
                    state_d   = bad_cmd_s ? ST_DONE : ST_SWAP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SWAP: begin
                k_d = k_q + AW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SWAP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SWAP);
        done_d = (state_d == ST_DONE);
        err_d  = done_d && cmd_err_d;
    end

    // Register-file update: pair swap while busy, host load otherwise, plus registered read.
    always_comb begin
        amp_re_d = amp_re_q;
        amp_im_d = amp_im_q;
`ifdef CONTROLLED_X_EN
        swap_en_s = !ctrl_en_q || (|(i0_s & (AW'(1) << ctrl_q)));
`else
        swap_en_s = 1'b1;
`endif
        if (state_q == ST_SWAP) begin
            if (swap_en_s) begin
                amp_re_d[i0_s] = amp_re_q[i1_s];
                amp_re_d[i1_s] = amp_re_q[i0_s];
                amp_im_d[i0_s] = amp_im_q[i1_s];
                amp_im_d[i1_s] = amp_im_q[i0_s];
            end else begin
                amp_re_d = amp_re_q;
                amp_im_d = amp_im_q;
            end
        end else if (ld_we) begin
            amp_re_d[ld_addr] = ld_re;
            amp_im_d[ld_addr] = ld_im;
        end else begin
            amp_re_d = amp_re_q;
            amp_im_d = amp_im_q;
        end
        rd_re_d = amp_re_q[rd_addr];
        rd_im_d = amp_im_q[rd_addr];
    end

    // State and register-file flops; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= {AW{1'b0}};
            t_q       <= {TW{1'b0}};
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_re_q   <= {TOTAL_WIDTH{1'b0}};
            rd_im_q   <= {TOTAL_WIDTH{1'b0}};
`ifdef CONTROLLED_X_EN
            ctrl_en_q <= 1'b0;
            ctrl_q    <= {TW{1'b0}};
`endif
            for (int i = 0; i < DEPTH; i++) begin
                amp_re_q[i] <= {TOTAL_WIDTH{1'b0}};
                amp_im_q[i] <= {TOTAL_WIDTH{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            t_q       <= t_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_re_q   <= rd_re_d;
            rd_im_q   <= rd_im_d;
`ifdef CONTROLLED_X_EN
            ctrl_en_q <= ctrl_en_d;
            ctrl_q    <= ctrl_d;
`endif
            amp_re_q  <= amp_re_d;
            amp_im_q  <= amp_im_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rd_re = rd_re_q;
    assign rd_im = rd_im_q;

endmodule

// File: tb/tb_x_gate_sv_engine.sv
// Directed self-checking bench for x_gate_sv_engine (N=3) with a readback scoreboard.
module tb_x_gate_sv_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_we;
    logic [2:0]  ld_addr;
    logic [15:0] ld_re, ld_im;
    logic [2:0]  rd_addr;
    logic [15:0] rd_re, rd_im;
    logic        start;
    logic [1:0]  target;
`ifdef CONTROLLED_X_EN
    logic        ctrl_en;
    logic [1:0]  ctrl;
`endif
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    logic [15:0] m_re [8];
    logic [15:0] m_im [8];

    always #5 clk = ~clk;

    x_gate_sv_engine #(.NUM_QUBITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_re   (ld_re),
        .ld_im   (ld_im),
        .rd_addr (rd_addr),
        .rd_re   (rd_re),
        .rd_im   (rd_im),
        .start   (start),
        .target  (target),
`ifdef CONTROLLED_X_EN
        .ctrl_en (ctrl_en),
        .ctrl    (ctrl),
`endif
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference X on the bench model: swap every (i, i with bit t set) where bit t of i is 0.
    task automatic model_x(input int t, input bit use_ctrl, input int c);
        logic [15:0] tr, ti;
        for (int i = 0; i < 8; i++) begin
            if (((i >> t) & 1) == 0 && (!use_ctrl || ((i >> c) & 1) == 1)) begin
                tr = m_re[i]; ti = m_im[i];
                m_re[i] = m_re[i + (1 << t)]; m_im[i] = m_im[i + (1 << t)];
                m_re[i + (1 << t)] = tr; m_im[i + (1 << t)] = ti;
            end
        end
    endtask

    task automatic load(input int a, input logic [15:0] re, input logic [15:0] im);
        ld_we = 1'b1; ld_addr = 3'(a); ld_re = re; ld_im = im;
        @(negedge clk);
        ld_we = 1'b0;
        m_re[a] = re; m_im[a] = im;
    endtask

    task automatic load_ramp();
        for (int j = 0; j < 8; j++) load(j, 16'(j), 16'(-j));
    endtask

    task automatic read_all(input string tag);
        logic [31:0] e;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            exp_q.push_back({m_re[a], m_im[a]});
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s_rd%0d", tag, a), {rd_re, rd_im}, e);
        end
    endtask

    task automatic wait_done(input int c0, input int b0, output int lat, output int bcnt,
                             output logic e);
        lat = 0; bcnt = b0; e = 1'b0;
        for (int c = c0; c <= 30; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c; e = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_cmd(input string tag, input int c0, input int b0,
                              input int exp_lat, input int exp_busy, input logic exp_err);
        int lat, bcnt;
        logic e;
        wait_done(c0, b0, lat, bcnt, e);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_cmd(input string tag, input int t, input int exp_lat,
                           input int exp_busy, input logic exp_err);
        start = 1'b1; target = 2'(t);
        @(negedge clk);
        start = 1'b0;
        finish_cmd(tag, 1, 0, exp_lat, exp_busy, exp_err);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = 3'd0; ld_re = 16'd0; ld_im = 16'd0;
        rd_addr = 3'd0; start = 1'b0; target = 2'd0;
`ifdef CONTROLLED_X_EN
        ctrl_en = 1'b0; ctrl = 2'd0;
`endif
        for (int j = 0; j < 8; j++) begin m_re[j] = 16'd0; m_im[j] = 16'd0; end
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd", {rd_re, rd_im}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_all("rst");

        // 1: target 0
        load_ramp();
        read_all("load");
        run_cmd("t0", 0, 5, 4, 1'b0);
        model_x(0, 1'b0, 0);
        read_all("t0");

        // 2: target 2
        load_ramp();
        run_cmd("t2", 2, 5, 4, 1'b0);
        model_x(2, 1'b0, 0);
        read_all("t2");

        // 3: self-inverse
        load_ramp();
        run_cmd("t1a", 1, 5, 4, 1'b0);
        run_cmd("t1b", 1, 5, 4, 1'b0);
        read_all("selfinv");

        // 4: out-of-range target
        run_cmd("t3", 3, 1, 0, 1'b1);
        read_all("t3");

        // load and start in the same IDLE cycle
        ld_we = 1'b1; ld_addr = 3'd5; ld_re = 16'h0055; ld_im = 16'hFFAB;
        start = 1'b1; target = 2'd0;
        @(negedge clk);
        ld_we = 1'b0; start = 1'b0;
        m_re[5] = 16'h0055; m_im[5] = 16'hFFAB;
        finish_cmd("ldstart", 1, 0, 5, 4, 1'b0);
        model_x(0, 1'b0, 0);
        read_all("ldstart");

        // 5: load and start while busy are dropped
        load_ramp();
        start = 1'b1; target = 2'd2;
        @(negedge clk);
        chk("busy_c1", {31'd0, busy}, 32'd1);
        ld_we = 1'b1; ld_addr = 3'd0; ld_re = 16'h7FFF; ld_im = 16'h0001;
        start = 1'b1; target = 2'd0;
        @(negedge clk);
        ld_we = 1'b0; start = 1'b0;
        finish_cmd("busyign", 2, 1, 5, 4, 1'b0);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) dcnt++;
        end
        chk("no_restart", 32'(dcnt), 32'd0);
        model_x(2, 1'b0, 0);
        read_all("busyign");

        // reset mid-SWAP
        start = 1'b1; target = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_rd", {rd_re, rd_im}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mrst_nodone", 32'(dcnt), 32'd0);
        for (int j = 0; j < 8; j++) begin m_re[j] = 16'd0; m_im[j] = 16'd0; end
        read_all("mrst");

`ifdef CONTROLLED_X_EN
        // 6: controlled X, ctrl=2 target=0
        load_ramp();
        ctrl_en = 1'b1; ctrl = 2'd2;
        run_cmd("cx", 0, 5, 4, 1'b0);
        model_x(0, 1'b1, 2);
        read_all("cx");
        ctrl = 2'd0;
        run_cmd("cx_same", 0, 1, 0, 1'b1);
        read_all("cx_same");
        ctrl_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
